jtframe_sdram_bank_arb: RTL and testbench

- Shares one SDRAM command engine between the four game bank ports (ba0..ba3) and the ROM-download prog port.
- Sits between the game instance/download logic and the SDRAM engine inside the frame.
- Serialises one transaction at a time and routes ack/rdy back to the winner.
- Prog port owns the engine exclusively while downloading is high.

---
 rtl/jtframe_sdram_arb_pkg.sv | 39 +++
 rtl/jtframe_sdram_rr_pick.sv | 35 +++
 rtl/jtframe_sdram_bank_arb.sv | 241 ++++++++++++++++++++++++
 tb/tb_jtframe_sdram_bank_arb.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_sdram_arb_pkg
//  Purpose  : Shared types for the SDRAM bank arbiter: FSM state encoding,
//             requester id type and the id reserved for the download port.
//  Contents : arb_state_e, req_id_t, PROG_ID, id_onehot()
//  Revision : 1.0  initial release
// ============================================================================
package jtframe_sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  // 0..3 are the game bank ports, 4 is the download port
  typedef logic [2:0] req_id_t;

  localparam req_id_t PROG_ID = 3'd4;

  // Maps a requester id onto {prog, ba[3:0]} so ack/rdy can be routed
  // with a single assignment and stay one-hot by construction.
  function automatic logic [4:0] id_onehot(input req_id_t id);
    logic [4:0] v;
    v = 5'b00000;
    case (id)
      3'd0:    v = 5'b00001;
      3'd1:    v = 5'b00010;
      3'd2:    v = 5'b00100;
      3'd3:    v = 5'b01000;
      PROG_ID: v = 5'b10000;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtframe_sdram_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_sdram_rr_pick
//  Purpose  : Combinational 4-way rotating priority encoder. The search
//             starts at ptr+1 and wraps, so the last winner (ptr) has the
//             lowest priority.
//  Ports    : req[3:0]  request vector
//             ptr[1:0]  index of the previous winner
//             valid     at least one request present
//             idx[1:0]  selected requester
//  Revision : 1.0  initial release
// ============================================================================
module jtframe_sdram_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  logic [1:0] cand;

  // Walk from the lowest priority slot (ptr+4 == ptr) up to ptr+1 so the
  // last hit written is the highest priority requester.
  always_comb begin
    valid = |req;
    idx   = ptr;
    cand  = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) idx = cand;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtframe_sdram_bank_arb.sv
`default_nettype none
// ============================================================================
//  Module   : jtframe_sdram_bank_arb
//  Purpose  : Shares one SDRAM command engine between the four game bank
//             ports and the ROM-download port. One transaction at a time;
//             ack/rdy are routed back to the winner as one-cycle pulses.
//  Ports    : ba*_addr/din/dsn, ba_rd, ba_wr -> bank requests (held to ack)
//             ba_ack, ba_rdy                 <- per-bank pulses
//             prog_*                         -> download port (owns engine
//                                               while downloading=1)
//             cmd_*                          <- command to engine
//             cmd_ack, cmd_rdy               -> engine handshake
//  Options  : JTFRAME_SDRAM_BA0_PRIO_EN - bank 0 wins whenever requesting,
//             bounded by STARVE consecutive grants while others wait.
//  Revision : 1.0  initial release
// ============================================================================
module jtframe_sdram_bank_arb #(
  parameter int          AW     = 22,
  parameter logic [3:0]  STARVE = 4'd15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic [AW-1:0] ba0_addr,
  input  logic [AW-1:0] ba1_addr,
  input  logic [AW-1:0] ba2_addr,
  input  logic [AW-1:0] ba3_addr,
  input  logic [3:0]    ba_rd,
  input  logic [3:0]    ba_wr,
  input  logic [15:0]   ba0_din,
  input  logic [15:0]   ba1_din,
  input  logic [15:0]   ba2_din,
  input  logic [15:0]   ba3_din,
  input  logic [1:0]    ba0_dsn,
  input  logic [1:0]    ba1_dsn,
  input  logic [1:0]    ba2_dsn,
  input  logic [1:0]    ba3_dsn,
  output logic [3:0]    ba_ack,
  output logic [3:0]    ba_rdy,
  input  logic [AW-1:0] prog_addr,
  input  logic [1:0]    prog_ba,
  input  logic          prog_rd,
  input  logic          prog_we,
  input  logic [15:0]   prog_data,
  input  logic [1:0]    prog_mask,
  output logic          prog_ack,
  output logic          prog_rdy,
  output logic          cmd_req,
  output logic          cmd_we,
  output logic [1:0]    cmd_ba,
  output logic [AW-1:0] cmd_addr,
  output logic [15:0]   cmd_din,
  output logic [1:0]    cmd_dsn,
  input  logic          cmd_ack,
  input  logic          cmd_rdy
);

  import jtframe_sdram_arb_pkg::*;

  arb_state_e    state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  req_id_t       win_q, win_d;
  logic          cmd_req_q, cmd_req_d;
  logic          cmd_we_q, cmd_we_d;
  logic [1:0]    cmd_ba_q, cmd_ba_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic [15:0]   cmd_din_q, cmd_din_d;
  logic [1:0]    cmd_dsn_q, cmd_dsn_d;
  logic [3:0]    ba_ack_q, ba_ack_d, ba_rdy_q, ba_rdy_d;
  logic          prog_ack_q, prog_ack_d, prog_rdy_q, prog_rdy_d;
  // pend: ack and rdy arrived together, rdy still owed
  // fin : the owed rdy has been pulsed, one more cycle before IDLE
  logic          pend_q, pend_d, fin_q, fin_d;

  logic [AW-1:0] addr_a [4];
  logic [15:0]   din_a  [4];
  logic [1:0]    dsn_a  [4];

  assign addr_a = '{ba0_addr, ba1_addr, ba2_addr, ba3_addr};
  assign din_a  = '{ba0_din,  ba1_din,  ba2_din,  ba3_din};
  assign dsn_a  = '{ba0_dsn,  ba1_dsn,  ba2_dsn,  ba3_dsn};

  logic [3:0] ba_req, pick_req;
  logic       pick_valid, grant_valid;
  logic [1:0] pick_idx, bank_idx;

  assign ba_req = ba_rd | ba_wr;

`ifdef JTFRAME_SDRAM_BA0_PRIO_EN
  logic [3:0] starve_q, starve_d;
  logic       others_w, starve_hit_w;

  assign others_w     = |ba_req[3:1];
  // Once bank 0 has used up its budget, mask it so round robin serves
  // one of the waiting banks instead.
  assign starve_hit_w = others_w && (starve_q == STARVE);
  assign pick_req     = starve_hit_w ? (ba_req & 4'b1110) : ba_req;
  assign bank_idx     = (ba_req[0] && !starve_hit_w) ? 2'd0 : pick_idx;
`else
  assign pick_req     = ba_req;
  assign bank_idx     = pick_idx;
`endif

  jtframe_sdram_rr_pick u_pick (
    .req   (pick_req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign grant_valid = downloading ? (prog_rd | prog_we) : pick_valid;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    cmd_req_d  = cmd_req_q;
    cmd_we_d   = cmd_we_q;
    cmd_ba_d   = cmd_ba_q;
    cmd_addr_d = cmd_addr_q;
    cmd_din_d  = cmd_din_q;
    cmd_dsn_d  = cmd_dsn_q;
    pend_d     = pend_q;
    fin_d      = fin_q;
    ba_ack_d   = 4'b0000;
    ba_rdy_d   = 4'b0000;
    prog_ack_d = 1'b0;
    prog_rdy_d = 1'b0;
`ifdef JTFRAME_SDRAM_BA0_PRIO_EN
    starve_d   = starve_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d   = ISSUE;
          cmd_req_d = 1'b1;
          if (downloading) begin
            win_d      = PROG_ID;
            cmd_we_d   = prog_we;
            cmd_ba_d   = prog_ba;
            cmd_addr_d = prog_addr;
            cmd_din_d  = prog_data;
            cmd_dsn_d  = prog_mask;
          end else begin
            win_d      = {1'b0, bank_idx};
            ptr_d      = bank_idx;
            cmd_we_d   = ba_wr[bank_idx];   // rd+wr together is a write
            cmd_ba_d   = bank_idx;
            cmd_addr_d = addr_a[bank_idx];
            cmd_din_d  = din_a[bank_idx];
            cmd_dsn_d  = dsn_a[bank_idx];
`ifdef JTFRAME_SDRAM_BA0_PRIO_EN
            if (bank_idx == 2'd0)
              starve_d = others_w ? starve_q + 4'd1 : 4'd0;
            else
              starve_d = 4'd0;
`endif
          end
        end
      end
      ISSUE: begin
        // cmd_rdy without a prior ack is meaningless here and ignored
        if (cmd_ack) begin
          cmd_req_d                = 1'b0;
          state_d                  = WAIT;
          pend_d                   = cmd_rdy;
          {prog_ack_d, ba_ack_d}   = id_onehot(win_q);
        end
      end
      WAIT: begin
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = IDLE;
        end else if (pend_q) begin
          pend_d                 = 1'b0;
          fin_d                  = 1'b1;
          {prog_rdy_d, ba_rdy_d} = id_onehot(win_q);
        end else if (cmd_rdy) begin
          state_d                = IDLE;
          {prog_rdy_d, ba_rdy_d} = id_onehot(win_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      win_q      <= 3'd0;
      cmd_req_q  <= 1'b0;
      cmd_we_q   <= 1'b0;
      cmd_ba_q   <= 2'd0;
      cmd_addr_q <= '0;
      cmd_din_q  <= 16'd0;
      cmd_dsn_q  <= 2'b11;
      ba_ack_q   <= 4'b0000;
      ba_rdy_q   <= 4'b0000;
      prog_ack_q <= 1'b0;
      prog_rdy_q <= 1'b0;
      pend_q     <= 1'b0;
      fin_q      <= 1'b0;
`ifdef JTFRAME_SDRAM_BA0_PRIO_EN
      starve_q   <= 4'd0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      cmd_req_q  <= cmd_req_d;
      cmd_we_q   <= cmd_we_d;
      cmd_ba_q   <= cmd_ba_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_din_q  <= cmd_din_d;
      cmd_dsn_q  <= cmd_dsn_d;
      ba_ack_q   <= ba_ack_d;
      ba_rdy_q   <= ba_rdy_d;
      prog_ack_q <= prog_ack_d;
      prog_rdy_q <= prog_rdy_d;
      pend_q     <= pend_d;
      fin_q      <= fin_d;
`ifdef JTFRAME_SDRAM_BA0_PRIO_EN
      starve_q   <= starve_d;
`endif
    end
  end

  assign ba_ack   = ba_ack_q;
  assign ba_rdy   = ba_rdy_q;
  assign prog_ack = prog_ack_q;
  assign prog_rdy = prog_rdy_q;
  assign cmd_req  = cmd_req_q;
  assign cmd_we   = cmd_we_q;
  assign cmd_ba   = cmd_ba_q;
  assign cmd_addr = cmd_addr_q;
  assign cmd_din  = cmd_din_q;
  assign cmd_dsn  = cmd_dsn_q;

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sdram_bank_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtframe_sdram_bank_arb
//  Purpose  : Directed self-checking bench for jtframe_sdram_bank_arb.
//             The engine side is driven by hand with fixed ack/rdy delays.
//             Bank-0 priority scenario is built with JTFRAME_SDRAM_BA0_PRIO_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_jtframe_sdram_bank_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_rd, ba_wr;
  logic [15:0] ba0_din, ba1_din, ba2_din, ba3_din;
  logic [1:0]  ba0_dsn, ba1_dsn, ba2_dsn, ba3_dsn;
  logic [3:0]  ba_ack, ba_rdy;
  logic [21:0] prog_addr;
  logic [1:0]  prog_ba;
  logic        prog_rd, prog_we;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic        prog_ack, prog_rdy;
  logic        cmd_req, cmd_we;
  logic [1:0]  cmd_ba;
  logic [21:0] cmd_addr;
  logic [15:0] cmd_din;
  logic [1:0]  cmd_dsn;
  logic        cmd_ack, cmd_rdy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  jtframe_sdram_bank_arb #(
    .AW     (22),
`ifdef JTFRAME_SDRAM_BA0_PRIO_EN
    .STARVE (4'd3)
`else
    .STARVE (4'd15)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .ba0_addr    (ba0_addr),
    .ba1_addr    (ba1_addr),
    .ba2_addr    (ba2_addr),
    .ba3_addr    (ba3_addr),
    .ba_rd       (ba_rd),
    .ba_wr       (ba_wr),
    .ba0_din     (ba0_din),
    .ba1_din     (ba1_din),
    .ba2_din     (ba2_din),
    .ba3_din     (ba3_din),
    .ba0_dsn     (ba0_dsn),
    .ba1_dsn     (ba1_dsn),
    .ba2_dsn     (ba2_dsn),
    .ba3_dsn     (ba3_dsn),
    .ba_ack      (ba_ack),
    .ba_rdy      (ba_rdy),
    .prog_addr   (prog_addr),
    .prog_ba     (prog_ba),
    .prog_rd     (prog_rd),
    .prog_we     (prog_we),
    .prog_data   (prog_data),
    .prog_mask   (prog_mask),
    .prog_ack    (prog_ack),
    .prog_rdy    (prog_rdy),
    .cmd_req     (cmd_req),
    .cmd_we      (cmd_we),
    .cmd_ba      (cmd_ba),
    .cmd_addr    (cmd_addr),
    .cmd_din     (cmd_din),
    .cmd_dsn     (cmd_dsn),
    .cmd_ack     (cmd_ack),
    .cmd_rdy     (cmd_rdy)
  );

  // Per-bank stimulus values, also used as expectations
  logic [21:0] ea [4];
  logic [15:0] ed [4];
  logic [1:0]  es [4];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction, entered in the cycle where cmd_req should first
  // be visible. Returns in the cycle after the rdy pulse (normal) or two
  // cycles after the ack pulse with cmd_req still low (ack+rdy together).
  task automatic txn(input string tag, input int id, input logic we,
                     input logic [21:0] addr, input logic [15:0] din,
                     input logic [1:0] dsn, input logic [1:0] ba,
                     input bit both, input bit keep);
    logic [4:0] oh;
    oh = 5'b00000;
    oh[id] = 1'b1;
    chk({tag, " req"},  32'(cmd_req), 32'd1);
    chk({tag, " we"},   32'(cmd_we), 32'(we));
    chk({tag, " ba"},   32'(cmd_ba), 32'(ba));
    chk({tag, " addr"}, 32'(cmd_addr), 32'(addr));
    chk({tag, " din"},  32'(cmd_din), 32'(din));
    chk({tag, " dsn"},  32'(cmd_dsn), 32'(dsn));
    step;
    chk({tag, " req_hold"}, 32'(cmd_req), 32'd1);
    chk({tag, " no_early_ack"}, 32'({prog_ack, ba_ack}), 32'd0);
    cmd_ack = 1'b1;
    cmd_rdy = both;
    step;
    cmd_ack = 1'b0;
    cmd_rdy = 1'b0;
    chk({tag, " ack"}, 32'({prog_ack, ba_ack}), 32'(oh));
    chk({tag, " req_drop"}, 32'(cmd_req), 32'd0);
    chk({tag, " no_early_rdy"}, 32'({prog_rdy, ba_rdy}), 32'd0);
    if (!keep) begin
      if (id == 4) begin
        prog_rd = 1'b0;
        prog_we = 1'b0;
      end else begin
        ba_rd[id] = 1'b0;
        ba_wr[id] = 1'b0;
      end
    end
    if (both) begin
      step;
      chk({tag, " ack_1cyc"}, 32'({prog_ack, ba_ack}), 32'd0);
      chk({tag, " rdy"}, 32'({prog_rdy, ba_rdy}), 32'(oh));
      chk({tag, " req_t2"}, 32'(cmd_req), 32'd0);
      step;
      chk({tag, " rdy_1cyc"}, 32'({prog_rdy, ba_rdy}), 32'd0);
      chk({tag, " req_t3"}, 32'(cmd_req), 32'd0);
    end else begin
      step;
      chk({tag, " ack_1cyc"}, 32'({prog_ack, ba_ack}), 32'd0);
      step;
      cmd_rdy = 1'b1;
      step;
      cmd_rdy = 1'b0;
      chk({tag, " rdy"}, 32'({prog_rdy, ba_rdy}), 32'(oh));
      chk({tag, " req_low"}, 32'(cmd_req), 32'd0);
    end
  endtask

  initial begin
    int order1 [4];
    order1 = '{1, 2, 3, 0};
    ea = '{22'h000100, 22'h011111, 22'h022222, 22'h033333};
    ed = '{16'h1000, 16'h1001, 16'h1002, 16'h1003};
    es = '{2'b00, 2'b01, 2'b10, 2'b11};

    rst = 1'b1;
    downloading = 1'b0;
    ba0_addr = ea[0]; ba1_addr = ea[1]; ba2_addr = ea[2]; ba3_addr = ea[3];
    ba0_din  = ed[0]; ba1_din  = ed[1]; ba2_din  = ed[2]; ba3_din  = ed[3];
    ba0_dsn  = es[0]; ba1_dsn  = es[1]; ba2_dsn  = es[2]; ba3_dsn  = es[3];
    ba_rd = 4'b0000;
    ba_wr = 4'b0000;
    prog_addr = 22'd0; prog_ba = 2'd0; prog_rd = 1'b0; prog_we = 1'b0;
    prog_data = 16'd0; prog_mask = 2'b00;
    cmd_ack = 1'b0;
    cmd_rdy = 1'b0;
    step;
    step;

    // Reset state
    chk("rst cmd_req",  32'(cmd_req), 32'd0);
    chk("rst cmd_we",   32'(cmd_we), 32'd0);
    chk("rst cmd_ba",   32'(cmd_ba), 32'd0);
    chk("rst cmd_addr", 32'(cmd_addr), 32'd0);
    chk("rst cmd_din",  32'(cmd_din), 32'd0);
    chk("rst cmd_dsn",  32'(cmd_dsn), 32'd3);
    chk("rst acks",     32'({prog_ack, ba_ack}), 32'd0);
    chk("rst rdys",     32'({prog_rdy, ba_rdy}), 32'd0);
    rst = 1'b0;

    // 1: all four banks reading, round robin from pointer 0 -> 1,2,3,0
    ba_rd = 4'b1111;
    step;
    for (int n = 0; n < 4; n++) begin
      txn($sformatf("t1_g%0d", n), order1[n], 1'b0, ea[order1[n]], ed[order1[n]],
          es[order1[n]], 2'(order1[n]), 1'b0, 1'b0);
      step;
    end
    chk("t1 idle_after", 32'(cmd_req), 32'd0);

    // 2: download owns the engine, bank 0 request is held off
    downloading = 1'b1;
    prog_we = 1'b1;
    prog_addr = 22'h1234;
    prog_mask = 2'b10;
    prog_ba = 2'd2;
    prog_data = 16'hC0DE;
    ba_rd = 4'b0001;
    step;
    txn("t2_prog", 4, 1'b1, 22'h1234, 16'hC0DE, 2'b10, 2'd2, 1'b0, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step;
      chk($sformatf("t2 held_req%0d", n), 32'(cmd_req), 32'd0);
      chk($sformatf("t2 held_ack%0d", n), 32'(ba_ack), 32'd0);
    end
    downloading = 1'b0;
    step;
    txn("t2_ba0", 0, 1'b0, ea[0], ed[0], es[0], 2'd0, 1'b0, 1'b0);

    // 3: rd and wr both set on bank 2 -> write
    ba2_din = 16'hBEEF;
    ba_rd[2] = 1'b1;
    ba_wr[2] = 1'b1;
    step;
    txn("t3_wr", 2, 1'b1, ea[2], 16'hBEEF, es[2], 2'd2, 1'b0, 1'b0);
    step;
    chk("t3 single_a", 32'(cmd_req), 32'd0);
    step;
    chk("t3 single_b", 32'(cmd_req), 32'd0);

    // 4: ack and rdy together, next command no earlier than t+4
    ba_rd[3] = 1'b1;
    step;
    ba_rd[0] = 1'b1;
    txn("t4_both", 3, 1'b0, ea[3], ed[3], es[3], 2'd3, 1'b1, 1'b0);
    step;
    txn("t4_next", 0, 1'b0, ea[0], ed[0], es[0], 2'd0, 1'b0, 1'b0);

    // 5: reset while waiting for rdy
    ba_rd[3] = 1'b1;
    step;
    chk("t5 req", 32'(cmd_req), 32'd1);
    chk("t5 ba",  32'(cmd_ba), 32'd3);
    step;
    cmd_ack = 1'b1;
    step;
    cmd_ack = 1'b0;
    chk("t5 ack", 32'(ba_ack), 32'h8);
    ba_rd[3] = 1'b0;
    step;
    rst = 1'b1;
    cmd_rdy = 1'b1;
    step;
    chk("t5 rst_req", 32'(cmd_req), 32'd0);
    chk("t5 rst_rdy", 32'({prog_rdy, ba_rdy}), 32'd0);
    chk("t5 rst_dsn", 32'(cmd_dsn), 32'd3);
    rst = 1'b0;
    cmd_rdy = 1'b0;
    step;
    chk("t5 post_rdy", 32'({prog_rdy, ba_rdy}), 32'd0);
    chk("t5 post_req", 32'(cmd_req), 32'd0);
    ba_rd[3] = 1'b1;
    step;
    txn("t5_again", 3, 1'b0, ea[3], ed[3], es[3], 2'd3, 1'b0, 1'b0);

`ifdef JTFRAME_SDRAM_BA0_PRIO_EN
    // 6: bank 0 priority with STARVE=3 -> 0,0,0,1,0
    begin
      int order6 [5];
      order6 = '{0, 0, 0, 1, 0};
      ba_rd = 4'b0011;
      step;
      for (int n = 0; n < 5; n++) begin
        txn($sformatf("t6_g%0d", n), order6[n], 1'b0, ea[order6[n]], ed[order6[n]],
            es[order6[n]], 2'(order6[n]), 1'b0, 1'b1);
        if (n == 4) ba_rd = 4'b0000;
        step;
      end
      chk("t6 idle_after", 32'(cmd_req), 32'd0);
    end
`endif

    step;
    chk("end idle", 32'(cmd_req), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
